// File: rtl/kmc_ser_pkg.sv
// Shared types and constants for the KMC11 BRG line-side byte serializer.
package kmc_ser_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } ser_state_t;

   localparam logic LINE_IDLE     = 1'b1;
   localparam logic LINE_START    = 1'b0;
   localparam int   MAX_DATA_BITS = 8;

endpackage

// File: rtl/kmc_ser_shift.sv
// Serializer shift register and data-bit counter; rotates right one place per enabled bit time.
module kmc_ser_shift
   import kmc_ser_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     load,
   input  logic [MAX_DATA_BITS-1:0] load_data,
   input  logic                     rotate,
   output logic                     next_bit,
   output logic                     last
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   logic [MAX_DATA_BITS-1:0] shift;
   logic [2:0]               count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift <= '0;
         count <= '0;
      end else if (clr) begin
         shift <= '0;
         count <= '0;
      end else if (load) begin
         shift <= load_data;
         count <= '0;
      end else if (rotate) begin
         shift <= {shift[0], shift[MAX_DATA_BITS-1:1]};
         count <= count + 3'd1;
      end
   end

   // The line output is registered in the top, so it needs the bit that will sit in shift[0] after this edge.
   always_comb begin
      next_bit = shift[0];
      if (load)
         next_bit = load_data[0];
      else if (rotate)
         next_bit = shift[1];
   end

   assign last = (count == LAST_IDX);

endmodule

// File: rtl/kmc_brg_ser.sv
// KMC11 BRG byte serializer: holding buffer, frame FSM and status flags.
// Optional odd parity bit after the data bits when KMC_SER_PARITY_EN is defined.
module kmc_brg_ser
   import kmc_ser_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kmcINIT,
   input  logic [7:0] kmcBRG,
   input  logic       kmcLDSER,
   input  logic       kmcBITCLKEN,
   output logic       kmcTXD,
   output logic       kmcTXBUSY,
   output logic       kmcTXEMPTY,
   output logic       kmcTXDONE,
   output logic       kmcTXOVR
);

   localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

   ser_state_t state, next_state;
   logic [7:0] buffer;
   logic       buf_full, stop_cnt, txd, done, ovr;
   logic       xfer, stop_last, rotate, last, next_bit, txd_next, done_next;
   logic       load_ok, ovr_set;
`ifdef KMC_SER_PARITY_EN
   logic       par_bit;
`endif

   assign load_ok   = kmcLDSER && !buf_full;
   assign ovr_set   = kmcLDSER && buf_full;
   assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
   assign rotate    = (state == DATA) && kmcBITCLKEN;

   kmc_ser_shift #(.DATA_BITS(DATA_BITS)) u_shift (
      .clk       (clk),
      .rst       (rst),
      .clr       (kmcINIT),
      .load      (xfer),
      .load_data (buffer),
      .rotate    (rotate),
      .next_bit  (next_bit),
      .last      (last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         buffer   <= '0;
         buf_full <= 1'b0;
         stop_cnt <= 1'b0;
         txd      <= LINE_IDLE;
         done     <= 1'b0;
         ovr      <= 1'b0;
`ifdef KMC_SER_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else if (kmcINIT) begin
         state    <= IDLE;
         buffer   <= '0;
         buf_full <= 1'b0;
         stop_cnt <= 1'b0;
         txd      <= LINE_IDLE;
         done     <= 1'b0;
         ovr      <= 1'b0;
`ifdef KMC_SER_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         state <= next_state;
         txd   <= txd_next;
         done  <= done_next;
         ovr   <= ovr | ovr_set;
         // A load in the same cycle as a transfer leaves the new byte pending.
         if (load_ok) begin
            buffer   <= kmcBRG & DATA_MASK;
            buf_full <= 1'b1;
         end else if (xfer) begin
            buf_full <= 1'b0;
         end
         if (state != STOP)
            stop_cnt <= 1'b0;
         else if (kmcBITCLKEN)
            stop_cnt <= stop_cnt + 1'b1;
`ifdef KMC_SER_PARITY_EN
         if (xfer)
            par_bit <= ~^buffer;
`endif
      end
   end

   always_comb begin
      next_state = state;
      xfer       = 1'b0;
      case (state)
         IDLE: begin
            if (buf_full) begin
               next_state = START;
               xfer       = 1'b1;
            end
         end
         START: begin
            if (kmcBITCLKEN)
               next_state = DATA;
         end
         DATA: begin
            if (kmcBITCLKEN && last)
`ifdef KMC_SER_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
         end
`ifdef KMC_SER_PARITY_EN
         PARITY: begin
            if (kmcBITCLKEN)
               next_state = STOP;
         end
`endif
         STOP: begin
            if (kmcBITCLKEN && stop_last) begin
               if (buf_full) begin
                  next_state = START;
                  xfer       = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      if (kmcINIT) begin
         next_state = IDLE;
         xfer       = 1'b0;
      end
   end

   always_comb begin
      txd_next = LINE_IDLE;
      case (next_state)
         START:  txd_next = LINE_START;
         DATA:   txd_next = next_bit;
`ifdef KMC_SER_PARITY_EN
         PARITY: txd_next = par_bit;
`endif
         default: txd_next = LINE_IDLE;
      endcase
      done_next = (state == STOP) && kmcBITCLKEN && stop_last;
   end

   assign kmcTXD     = txd;
   assign kmcTXBUSY  = (state != IDLE);
   assign kmcTXEMPTY = !buf_full;
   assign kmcTXDONE  = done;
   assign kmcTXOVR   = ovr;

endmodule

// File: tb/tb_kmc_brg_ser.sv
// Directed plus randomized bench for kmc_brg_ser; expected line bits come from a frame model built per byte.
module tb_kmc_brg_ser;

   localparam int DB = 8;
   localparam int SB = 1;
`ifdef KMC_SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kmcINIT = 1'b0;
   logic [7:0] kmcBRG = 8'h00;
   logic       kmcLDSER = 1'b0;
   logic       kmcBITCLKEN = 1'b0;
   logic       kmcTXD, kmcTXBUSY, kmcTXEMPTY, kmcTXDONE, kmcTXOVR;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_bits[$];

   kmc_brg_ser #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
      .clk         (clk),
      .rst         (rst),
      .kmcINIT     (kmcINIT),
      .kmcBRG      (kmcBRG),
      .kmcLDSER    (kmcLDSER),
      .kmcBITCLKEN (kmcBITCLKEN),
      .kmcTXD      (kmcTXD),
      .kmcTXBUSY   (kmcTXBUSY),
      .kmcTXEMPTY  (kmcTXEMPTY),
      .kmcTXDONE   (kmcTXDONE),
      .kmcTXOVR    (kmcTXOVR)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      kmcBRG   = b;
      kmcLDSER = 1'b1;
      tick();
      kmcLDSER = 1'b0;
   endtask

   task automatic pulseEnable();
      kmcBITCLKEN = 1'b1;
      tick();
      kmcBITCLKEN = 1'b0;
   endtask

   // Line levels of one async frame: start, data LSB first, optional odd parity, stop bits.
   function automatic void buildFrame(input logic [7:0] d);
      logic p;
      p = 1'b0;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) begin
         exp_bits.push_back(d[i]);
         p ^= d[i];
      end
      if (PB != 0)
         exp_bits.push_back(~p);
      for (int i = 0; i < SB; i++)
         exp_bits.push_back(1'b1);
   endfunction

   task automatic startFrame(input logic [7:0] d);
      applyStimulus(d);
      checkOutput("load_empty", kmcTXEMPTY, 1'b0);
      tick();
      checkOutput("xfer_empty", kmcTXEMPTY, 1'b1);
   endtask

   task automatic runFrame(input logic [7:0] d, input logic chained, input int gap,
                           input int load_at, input logic [7:0] load_val);
      buildFrame(d);
      checkOutput("start_bit", kmcTXD, exp_bits[0]);
      checkOutput("busy_in_frame", kmcTXBUSY, 1'b1);
      for (int k = 1; k < exp_bits.size(); k++) begin
         pulseEnable();
         checkOutput($sformatf("frame_bit%0d_d%02h", k, d), kmcTXD, exp_bits[k]);
         checkOutput("done_early", kmcTXDONE, 1'b0);
         for (int j = 0; j < gap; j++) begin
            if (k == load_at && j == 0)
               applyStimulus(load_val);
            else
               tick();
         end
         checkOutput($sformatf("bit_hold%0d_d%02h", k, d), kmcTXD, exp_bits[k]);
      end
      pulseEnable();
      checkOutput("done_pulse", kmcTXDONE, 1'b1);
      checkOutput("end_txd", kmcTXD, chained ? 1'b0 : 1'b1);
      checkOutput("end_busy", kmcTXBUSY, chained);
      tick();
      checkOutput("done_clear", kmcTXDONE, 1'b0);
   endtask

   initial begin
      logic [7:0] d;
      int         gap;

      // Power-on reset and reset values
      #1 rst = 1'b0;
      #10;
      checkOutput("rst_txd", kmcTXD, 1'b1);
      checkOutput("rst_busy", kmcTXBUSY, 1'b0);
      checkOutput("rst_empty", kmcTXEMPTY, 1'b1);
      checkOutput("rst_done", kmcTXDONE, 1'b0);
      checkOutput("rst_ovr", kmcTXOVR, 1'b0);
      rst = 1'b1;
      tick();

      // Async reset in the middle of a frame with an overrun pending
      startFrame(8'h96);
      for (int k = 0; k < 3; k++) begin
         pulseEnable();
         tick();
      end
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      checkOutput("pre_rst_ovr", kmcTXOVR, 1'b1);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_txd", kmcTXD, 1'b1);
      checkOutput("arst_busy", kmcTXBUSY, 1'b0);
      checkOutput("arst_empty", kmcTXEMPTY, 1'b1);
      checkOutput("arst_ovr", kmcTXOVR, 1'b0);
      #3 rst = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         pulseEnable();
         checkOutput("post_rst_done", kmcTXDONE, 1'b0);
         checkOutput("idle_en_txd", kmcTXD, 1'b1);
         checkOutput("idle_en_busy", kmcTXBUSY, 1'b0);
      end

      // Single frame, enable every 4 clocks
      startFrame(8'hA5);
      runFrame(8'hA5, 1'b0, 3, -1, 8'h00);
      checkOutput("a5_empty", kmcTXEMPTY, 1'b1);

      // Back-to-back frames: second byte loaded while the first is in DATA
      startFrame(8'h3C);
      runFrame(8'h3C, 1'b1, 3, 3, 8'h81);
      checkOutput("b2b_empty", kmcTXEMPTY, 1'b1);
      runFrame(8'h81, 1'b0, 3, -1, 8'h00);

      // Overrun: third load while the buffer still holds the second byte
      applyStimulus(8'h11);
      tick();
      applyStimulus(8'h22);
      checkOutput("ovr_second", kmcTXOVR, 1'b0);
      checkOutput("full_second", kmcTXEMPTY, 1'b0);
      applyStimulus(8'h33);
      checkOutput("ovr_third", kmcTXOVR, 1'b1);
      checkOutput("full_third", kmcTXEMPTY, 1'b0);
      runFrame(8'h11, 1'b1, 3, -1, 8'h00);
      runFrame(8'h22, 1'b0, 3, -1, 8'h00);
      checkOutput("ovr_sticky", kmcTXOVR, 1'b1);
      kmcINIT = 1'b1;
      tick();
      kmcINIT = 1'b0;
      checkOutput("ovr_init_clear", kmcTXOVR, 1'b0);

      // Parity-sensitive patterns (odd and even ones-count)
      startFrame(8'h03);
      runFrame(8'h03, 1'b0, 3, -1, 8'h00);
      startFrame(8'h07);
      runFrame(8'h07, 1'b0, 3, -1, 8'h00);

      // INIT during the stop bit, together with a load and an enable
      startFrame(8'hC3);
      for (int k = 0; k < 1 + DB + PB; k++) begin
         pulseEnable();
         tick();
      end
      checkOutput("stop_level", kmcTXD, 1'b1);
      kmcINIT     = 1'b1;
      kmcLDSER    = 1'b1;
      kmcBITCLKEN = 1'b1;
      kmcBRG      = 8'h5A;
      tick();
      kmcINIT     = 1'b0;
      kmcLDSER    = 1'b0;
      kmcBITCLKEN = 1'b0;
      checkOutput("init_txd", kmcTXD, 1'b1);
      checkOutput("init_busy", kmcTXBUSY, 1'b0);
      checkOutput("init_empty", kmcTXEMPTY, 1'b1);
      checkOutput("init_done", kmcTXDONE, 1'b0);
      checkOutput("init_ovr", kmcTXOVR, 1'b0);
      tick();
      tick();
      checkOutput("init_load_ignored", kmcTXEMPTY, 1'b1);
      checkOutput("init_stays_idle", kmcTXBUSY, 1'b0);

      // Random bytes with random enable spacing
      for (int n = 0; n < 6; n++) begin
         d   = 8'($urandom);
         gap = $urandom_range(1, 4);
         startFrame(d);
         runFrame(d, 1'b0, gap, -1, 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kmc_brg_ser.md
Name: kmc_brg_ser

Overview:
KMC11 line-side byte serializer: the read-out end of the Branch Register (BRG) path. Microcode moves a byte into BRG, then strobes this block, which takes the byte into a one-byte holding buffer. The block transfers the byte to a shift register and emits it as an asynchronous serial frame, LSB first, paced by an external bit-clock enable. It reports buffer-empty and frame-done status back to the microprocessor's branch/IBUS logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); BRG bits above DATA_BITS are ignored.
STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
kmcINIT  input  1  synchronous initialize, same effect as reset
kmcBRG  input  8  byte source (BRG register contents)
kmcLDSER  input  1  one-cycle strobe: capture kmcBRG into holding buffer
kmcBITCLKEN  input  1  one-cycle bit-time enable
kmcTXD  output  1  serial data out (idle = 1)
kmcTXBUSY  output  1  frame in progress
kmcTXEMPTY  output  1  holding buffer empty (may load)
kmcTXDONE  output  1  one-cycle pulse at end of final stop bit
kmcTXOVR  output  1  sticky overrun: load while buffer full

Behaviour:
- Reset (rst=0, async) or kmcINIT=1 (sync, highest priority): kmcTXD=1, kmcTXBUSY=0, kmcTXEMPTY=1, kmcTXDONE=0, kmcTXOVR=0. The state machine returns to IDLE and the holding buffer and shift register clear to 0.
- Reset or INIT mid-frame aborts the frame. kmcTXD returns to 1 on the next edge (immediately for async reset). No DONE pulse is generated.
- Load: kmcLDSER with kmcTXEMPTY=1 captures kmcBRG[DATA_BITS-1:0] and clears kmcTXEMPTY on the next edge.
- If kmcLDSER arrives with kmcTXEMPTY=0, the buffer is unchanged and kmcTXOVR is set. kmcTXOVR clears only on reset or INIT.
- Transfer happens in IDLE with the buffer full, on any cycle (no bit enable required):
  - buffer moves to the shift register;
  - kmcTXEMPTY sets;
  - kmcTXBUSY sets;
  - state becomes START.
- A load and a transfer in the same cycle are allowed: the new byte stays in the buffer and kmcTXEMPTY stays 0.
- State machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All advances other than IDLE->START are gated by kmcBITCLKEN. Each state holds kmcTXD for exactly one enabled bit time.
  - START: kmcTXD=0 from entry until the first kmcBITCLKEN; then DATA.
  - DATA: kmcTXD = shift[0]. On each enable the register rotates right by one (shift <= {shift[0], shift[7:1]}) and a 3-bit counter increments. After DATA_BITS enables, the state becomes PARITY or STOP.
  - STOP: kmcTXD=1 for STOP_BITS enables. On the last one:
    - kmcTXDONE pulses for one cycle;
    - if the buffer is full, the next frame transfers directly to START with no idle bit and kmcTXBUSY stays 1;
    - otherwise the state returns to IDLE and kmcTXBUSY clears.
- kmcTXD is registered; the frame edge aligns with the clk edge following the enable.
- kmcBITCLKEN while IDLE has no effect.
- Frame length = 1 + DATA_BITS + [1] + STOP_BITS enables.

Optional Feature:
KMC_SER_PARITY_EN.
- Defined: adds one odd-parity bit after the data bits, in state PARITY. Parity is the XOR-reduction of the transferred data bits, inverted, and is latched at transfer time.
- Undefined: the PARITY state, its parity flop and its logic are absent; DATA goes directly to STOP.

Decomposition:
- Shared package kmc_ser_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP) as a 3-bit typedef;
  - constants for idle line level (1), start level (0) and max DATA_BITS (8).
- One natural sub-module, kmc_ser_shift: the shift register plus bit counter, with load, rotate-enable and last-bit outputs.
- The FSM, holding buffer and status flags stay in the top.

Test Plan:
1. Reset with rst=0 mid-frame -> kmcTXD=1, BUSY=0, EMPTY=1, OVR=0 immediately; no DONE afterward.
2. Load 0xA5, DATA_BITS=8, one enable every 4 clocks -> kmcTXD sequence 0,1,0,1,0,0,1,0,1,1. DONE pulses once after the 10th enable; BUSY then drops.
3. Load 0x3C, then load 0x81 while the first frame is in DATA -> frames back-to-back with no idle bit between stop and start; EMPTY=1 after the second transfer; two DONE pulses.
4. Load three bytes with no frame finishing in between -> third load sets OVR=1; the buffer keeps the second byte; OVR stays 1 until kmcINIT.
5. With KMC_SER_PARITY_EN, load 0x03 -> parity bit 1 emitted before stop, frame of 11 enables. Load 0x07 -> parity bit 0.
6. Pulse kmcINIT during PARITY/STOP, same cycle as kmcLDSER -> all outputs at reset values next edge; the load is ignored.
